// File: rtl/vga_scanout.sv
// vga_scanout - VGA timing generator and framebuffer scanout stage.
//
// Walks a raster of H_TOTAL x V_TOTAL pixel ticks. For every visible pixel it
// issues a framebuffer word address, unpacks the returned RGB332 byte with
// integer upscaling, and drives 4:4:4 RGB plus active-low syncs. A pixel
// position reaches the outputs exactly two ticks after the counters show it.
//
// Ports:
//   Clock       system clock (shared with the cpu framebuffer port)
//   Reset       asynchronous, active-high reset
//   GPUAddress  framebuffer word address (held during blanking)
//   GPUData     framebuffer word, valid one Clock after GPUAddress
//   VGARed      4-bit red
//   VGAGreen    4-bit green
//   VGABlue     4-bit blue
//   VGAHSync    horizontal sync, active low
//   VGAVSync    vertical sync, active low
//   FrameStart  one-Clock pulse when pixel (0,0) reaches the outputs
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SCALE      = 2,
  parameter int CLK_DIV    = 2,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] GPUAddress,
  input  logic [31:0]           GPUData,
  output logic [3:0]            VGARed,
  output logic [3:0]            VGAGreen,
  output logic [3:0]            VGABlue,
  output logic                  VGAHSync,
  output logic                  VGAVSync,
  output logic                  FrameStart
);

  localparam int H_TOTAL        = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL        = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int FB_W           = H_ACTIVE / SCALE;
  localparam int WORDS_PER_LINE = FB_W / 4;

  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = $clog2(CLK_DIV);
  localparam int SCALE_SH = $clog2(SCALE);
  localparam int LW       = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [DW-1:0] D_LAST     = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] L_LAST     = LW'(SCALE - 1);
  localparam logic [ADDR_WIDTH-1:0] WPL = ADDR_WIDTH'(WORDS_PER_LINE);

  // RGB332 -> RGB444 by replicating the top bits into the missing LSBs.
  function automatic logic [11:0] rgb332_expand(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  // Tick divider and stage-0 raster state
  logic [DW-1:0]         div_r;
  logic [HW-1:0]         hcount_r;
  logic [VW-1:0]         vcount_r;
  logic [LW-1:0]         linerep_r;
  logic [ADDR_WIDTH-1:0] rowbase_r;

  // Stage-0 decode
  logic                  tick_s;
  logic                  h_wrap_s;
  logic                  v_wrap_s;
  logic                  active_s;
  logic                  hsync_pulse_s;
  logic                  vsync_pulse_s;
  logic                  first_s;
  logic [HW-1:0]         col_s;
  logic [ADDR_WIDTH-1:0] word_off_s;

  // Stage-1 registers
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [1:0]            pixsel_r;
  logic                  active_1_r;
  logic                  hsync_1_r;
  logic                  vsync_1_r;
  logic                  first_1_r;

  // Stage-2 selection and output registers
  logic [7:0]            pixel_s;
  logic [11:0]           rgb_s;
  logic [3:0]            red_r;
  logic [3:0]            green_r;
  logic [3:0]            blue_r;
  logic                  hsync_n_r;
  logic                  vsync_n_r;
  logic                  frame_start_r;

  // Stage-0 decode of the raster position (sync flags are active-high here)
  always_comb begin
    tick_s        = (div_r == D_LAST);
    h_wrap_s      = (hcount_r == H_LAST);
    v_wrap_s      = (vcount_r == V_LAST);
    active_s      = (hcount_r < H_ACT) && (vcount_r < V_ACT);
    hsync_pulse_s = (hcount_r >= H_SYNC_BEG) && (hcount_r < H_SYNC_END);
    vsync_pulse_s = (vcount_r >= V_SYNC_BEG) && (vcount_r < V_SYNC_END);
    first_s       = (hcount_r == '0) && (vcount_r == '0);
    col_s         = hcount_r >> SCALE_SH;
    word_off_s    = ADDR_WIDTH'(col_s >> 2'd2);
  end

  // Pixel-tick divider
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DW'(1'b1);
    end
  end

  // Raster counters, line-repeat counter and framebuffer row base
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hcount_r  <= '0;
      vcount_r  <= '0;
      linerep_r <= '0;
      rowbase_r <= '0;
    end else if (tick_s) begin
      if (h_wrap_s) begin
        hcount_r <= '0;
        if (v_wrap_s) begin
          vcount_r <= '0;
        end else begin
          vcount_r <= vcount_r + VW'(1'b1);
        end
        // Leaving the last visible line rewinds the row base right away, so
        // it never steps past the final framebuffer row.
        if (v_wrap_s || (vcount_r == V_ACT_LAST)) begin
          linerep_r <= '0;
          rowbase_r <= '0;
        end else if (vcount_r < V_ACT) begin
          if (linerep_r == L_LAST) begin
            linerep_r <= '0;
            rowbase_r <= rowbase_r + WPL;
          end else begin
            linerep_r <= linerep_r + LW'(1'b1);
          end
        end
      end else begin
        hcount_r <= hcount_r + HW'(1'b1);
      end
    end
  end

  // Stage 1: framebuffer address plus the control that must follow the data
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_r     <= '0;
      pixsel_r   <= '0;
      active_1_r <= 1'b0;
      hsync_1_r  <= 1'b0;
      vsync_1_r  <= 1'b0;
      first_1_r  <= 1'b0;
    end else if (tick_s) begin
      // Address only moves on visible pixels; blanking holds the last word.
      if (active_s) begin
        addr_r <= rowbase_r + word_off_s;
      end
      pixsel_r   <= col_s[1:0];
      active_1_r <= active_s;
      hsync_1_r  <= hsync_pulse_s;
      vsync_1_r  <= vsync_pulse_s;
      first_1_r  <= first_s;
    end
  end

  // Stage 2: byte select within the returned word and blanking
  always_comb begin
    pixel_s = GPUData[7:0];
    case (pixsel_r)
      2'd0:    pixel_s = GPUData[7:0];
      2'd1:    pixel_s = GPUData[15:8];
      2'd2:    pixel_s = GPUData[23:16];
      2'd3:    pixel_s = GPUData[31:24];
      default: pixel_s = GPUData[7:0];
    endcase
    if (active_1_r) begin
      rgb_s = rgb332_expand(pixel_s);
    end else begin
      rgb_s = 12'h000;
    end
  end

  // Stage 2: registered video outputs and the frame-start strobe
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      red_r         <= 4'h0;
      green_r       <= 4'h0;
      blue_r        <= 4'h0;
      hsync_n_r     <= 1'b1;
      vsync_n_r     <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      // Strobe only on the tick edge itself, so it lasts one Clock.
      frame_start_r <= tick_s & first_1_r;
      if (tick_s) begin
        red_r     <= rgb_s[11:8];
        green_r   <= rgb_s[7:4];
        blue_r    <= rgb_s[3:0];
        hsync_n_r <= ~hsync_1_r;
        vsync_n_r <= ~vsync_1_r;
      end
    end
  end

  assign GPUAddress = addr_r;
  assign VGARed     = red_r;
  assign VGAGreen   = green_r;
  assign VGABlue    = blue_r;
  assign VGAHSync   = hsync_n_r;
  assign VGAVSync   = vsync_n_r;
  assign FrameStart = frame_start_r;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout - self-checking bench for vga_scanout.
//   dut_a: default timing, SCALE=2, CLK_DIV=2, address-encoded memory.
//   dut_b: tiny raster (H 8/1/2/1, V 4/1/1/1), SCALE=2, CLK_DIV=3, scoreboard.
//   dut_c: tiny raster, SCALE=1, CLK_DIV=2, constant word 0xE01C03FF.
module tb_vga_scanout;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic reset_a, reset_b, reset_c;

  logic [15:0] addr_a, addr_b, addr_c;
  logic [31:0] data_a, data_b, data_c;
  logic [31:0] mem_q_a, mem_q_b;
  logic        force_ones_a = 1'b0;
  logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b, red_c, green_c, blue_c;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b, hs_c, vs_c, fs_c;

  int total = 0;
  int bad   = 0;
  int cyc_a = 0, cyc_b = 0, cyc_c = 0;
  logic b_done = 1'b0;

  vga_scanout dut_a (
    .Clock(Clock), .Reset(reset_a), .GPUAddress(addr_a), .GPUData(data_a),
    .VGARed(red_a), .VGAGreen(green_a), .VGABlue(blue_a),
    .VGAHSync(hs_a), .VGAVSync(vs_a), .FrameStart(fs_a));

  vga_scanout #(.H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                .SCALE(2), .CLK_DIV(3), .ADDR_WIDTH(16)) dut_b (
    .Clock(Clock), .Reset(reset_b), .GPUAddress(addr_b), .GPUData(data_b),
    .VGARed(red_b), .VGAGreen(green_b), .VGABlue(blue_b),
    .VGAHSync(hs_b), .VGAVSync(vs_b), .FrameStart(fs_b));

  vga_scanout #(.H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                .SCALE(1), .CLK_DIV(2), .ADDR_WIDTH(16)) dut_c (
    .Clock(Clock), .Reset(reset_c), .GPUAddress(addr_c), .GPUData(data_c),
    .VGARed(red_c), .VGAGreen(green_c), .VGABlue(blue_c),
    .VGAHSync(hs_c), .VGAVSync(vs_c), .FrameStart(fs_c));

  // Word at address a holds bytes a, a+1, a+2, a+3 (pixel 0 in the low byte).
  function automatic logic [31:0] memword(input logic [15:0] addr);
    logic [7:0] a;
    a = addr[7:0];
    return {a + 8'd3, a + 8'd2, a + 8'd1, a};
  endfunction

  function automatic logic [11:0] expand(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y, input int ha,
                                            input int va, input int scale, input int wpl);
    int col, a;
    logic [7:0] b;
    if (x >= ha || y >= va) return 12'h000;
    col = x / scale;
    a   = (y / scale) * wpl + col / 4;
    b   = 8'(a + col % 4);
    return expand(b);
  endfunction

  function automatic logic model_sync_n(input int c, input int act, input int fp, input int sw);
    return !(c >= act + fp && c < act + fp + sw);
  endfunction

  // Synchronous-read framebuffer models, one Clock of latency.
  always_ff @(posedge Clock) begin
    mem_q_a <= memword(addr_a);
    mem_q_b <= memword(addr_b);
  end
  assign data_a = force_ones_a ? 32'hFFFF_FFFF : mem_q_a;
  assign data_b = mem_q_b;
  assign data_c = 32'hE01C_03FF;

  always @(posedge Clock or posedge reset_a) if (reset_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
  always @(posedge Clock or posedge reset_b) if (reset_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;
  always @(posedge Clock or posedge reset_c) if (reset_c) cyc_c <= 0; else cyc_c <= cyc_c + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function int cur_cyc(input int which);
    return (which == 0) ? cyc_a : cyc_c;
  endfunction

  // Wait (on negedges) until the chosen instance has seen n Clocks since reset.
  task automatic wait_cyc(input int which, input int n);
    int g;
    g = 0;
    while (cur_cyc(which) < n && g < 60000) begin
      @(negedge Clock);
      g++;
    end
    if (cur_cyc(which) < n) check("wait timeout", cur_cyc(which), n);
  endtask

  typedef struct { int k; logic [15:0] addr; } addr_vec_t;
  typedef struct { int x; logic [11:0] rgb; logic hs; } pix_vec_t;
  typedef struct packed { logic [11:0] rgb; logic hs; logic vs; logic fs; } out_t;

  // Scoreboard for dut_b: push expectation at the tick a position enters
  // stage 1, pop it on the following tick when stage 2 shows it.
  initial begin
    out_t sb_q[$];
    out_t e;
    logic [15:0] exp_addr_b;
    int k, p, x, y;
    exp_addr_b = 16'h0000;
    forever begin
      @(negedge Clock);
      if (!reset_b && cyc_b > 0 && !b_done) begin
        if (cyc_b % 3 == 0) begin
          k = cyc_b / 3;
          p = k - 1;
          x = p % 12;
          y = (p / 12) % 7;
          if (x < 8 && y < 4) exp_addr_b = 16'(y / 2 + (x / 2) / 4);
          check("B addr", addr_b, exp_addr_b);
          sb_q.push_back('{model_rgb(x, y, 8, 4, 2, 1), model_sync_n(x, 8, 1, 2),
                           model_sync_n(y, 4, 1, 1), (x == 0 && y == 0)});
          if (k >= 2 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("B rgb", {red_b, green_b, blue_b}, e.rgb);
            check("B hsync", hs_b, e.hs);
            check("B vsync", vs_b, e.vs);
            check("B framestart", fs_b, e.fs);
          end
          if (k == 3 * 84 + 2) b_done = 1'b1;
        end else begin
          check("B fs idle", fs_b, 1'b0);
        end
      end
    end
  end

  initial begin
    addr_vec_t atab[10];
    pix_vec_t  ctab[12];

    // Address after stage 1 loads (x,y): tick k = y*800 + x + 1.
    atab = '{'{1, 16'd0},    '{8, 16'd0},    '{9, 16'd1},    '{640, 16'd79},
             '{701, 16'd79}, '{800, 16'd79}, '{801, 16'd0},  '{1601, 16'd80},
             '{1616, 16'd81}, '{2240, 16'd159}};
    ctab = '{'{0, 12'hFFF, 1'b1}, '{1, 12'h00F, 1'b1}, '{2, 12'h0F0, 1'b1},
             '{3, 12'hF00, 1'b1}, '{4, 12'hFFF, 1'b1}, '{5, 12'h00F, 1'b1},
             '{6, 12'h0F0, 1'b1}, '{7, 12'hF00, 1'b1}, '{8, 12'h000, 1'b1},
             '{9, 12'h000, 1'b0}, '{10, 12'h000, 1'b0}, '{11, 12'h000, 1'b1}};

    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    #8;
    check("A reset rgb", {red_a, green_a, blue_a}, 12'h000);
    check("A reset hsync", hs_a, 1'b1);
    check("A reset vsync", vs_a, 1'b1);
    check("A reset addr", addr_a, 16'h0000);
    check("A reset fs", fs_a, 1'b0);
    #2;
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;

    fork
      begin : seq_a
        int tidx, k, p, x, y;
        logic [11:0] exp_rgb;
        tidx = 0;
        for (int n = 1; n <= 4804; n++) begin
          wait_cyc(0, n);
          if (n % 2 == 1) begin
            check("A fs idle", fs_a, 1'b0);
          end else begin
            k = n / 2;
            if (tidx < 10 && atab[tidx].k == k) begin
              check("A addr", addr_a, atab[tidx].addr);
              tidx++;
            end
            if (k >= 2) begin
              p = k - 2; x = p % 800; y = p / 800;
              if (y == 1) exp_rgb = (x < 640) ? 12'hFFF : 12'h000;
              else        exp_rgb = model_rgb(x, y, 640, 480, 2, 80);
              check("A rgb", {red_a, green_a, blue_a}, exp_rgb);
              check("A hsync", hs_a, model_sync_n(x, 640, 16, 96));
              check("A vsync", vs_a, model_sync_n(y, 480, 10, 2));
              check("A framestart", fs_a, (p == 0));
            end else begin
              check("A first tick rgb", {red_a, green_a, blue_a}, 12'h000);
              check("A first tick hsync", hs_a, 1'b1);
            end
            if (k == 801)  force_ones_a = 1'b1;
            if (k == 1601) force_ones_a = 1'b0;
          end
        end
        check("A addr table used", tidx, 10);

        // Mid-line reset while (300,3) is on the outputs.
        wait_cyc(0, 5404);
        #2;
        reset_a = 1'b1;
        #1;
        check("A midreset rgb", {red_a, green_a, blue_a}, 12'h000);
        check("A midreset hsync", hs_a, 1'b1);
        check("A midreset vsync", vs_a, 1'b1);
        check("A midreset addr", addr_a, 16'h0000);
        check("A midreset fs", fs_a, 1'b0);
        repeat (3) @(negedge Clock);
        reset_a = 1'b0;
        wait_cyc(0, 1);
        check("A rel c1 addr", addr_a, 16'h0000);
        check("A rel c1 fs", fs_a, 1'b0);
        wait_cyc(0, 2);
        check("A rel c2 addr", addr_a, 16'h0000);
        wait_cyc(0, 3);
        check("A rel c3 fs", fs_a, 1'b0);
        wait_cyc(0, 4);
        check("A rel c4 fs", fs_a, 1'b1);
        wait_cyc(0, 5);
        check("A rel c5 fs", fs_a, 1'b0);
        wait_cyc(0, 18);
        check("A rel x8 addr", addr_a, 16'h0001);
      end
      begin : seq_c
        for (int i = 0; i < 12; i++) begin
          wait_cyc(1, 2 * (ctab[i].x + 2));
          check("C rgb332", {red_c, green_c, blue_c}, ctab[i].rgb);
          check("C hsync", hs_c, ctab[i].hs);
        end
      end
    join

    check("B scoreboard ran", b_done, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
